// File: rtl/seg_capture_pkg.sv
// Shared definitions for the seg_capture block: hex segment table, FSM
// encoding and default geometry.
package seg_capture_pkg;

  localparam int NDIG_DEF       = 4;
  localparam int STABLE_CYC_DEF = 8;

  // Active-high segment patterns (bits 6:0 = g..a); entry i decodes to nibble i.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h71, 7'h79, 7'h5E, 7'h39, 7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    COLLECT = 1'b0,
    PRESENT = 1'b1
  } state_t;

endpackage

// File: rtl/seg_capture_seg_to_hex.sv
// Combinational lookup of a 7-segment pattern into its hex nibble; patterns
// outside the table decode to 0 with err set.
module seg_to_hex
  import seg_capture_pkg::*;
(
  input  logic [6:0] pat,
  output logic [3:0] nib,
  output logic       err
);

  always_comb begin
    nib = 4'd0;
    err = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (pat == SEG_TABLE[i]) begin
        nib = 4'(i);
        err = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg_capture.sv
// Snoops a multiplexed 7-segment display bus, debounces each digit dwell and
// assembles full frames of decoded digits for a valid/ready consumer.
module seg_capture
  import seg_capture_pkg::*;
#(
  parameter int NDIG       = NDIG_DEF,
  parameter int STABLE_CYC = STABLE_CYC_DEF
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [7:0]          seg_n,
  input  logic [NDIG-1:0]     dig_en_n,
  output logic [4*NDIG-1:0]   out_hex,
  output logic [NDIG-1:0]     out_dp,
  output logic [NDIG-1:0]     out_err,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                overrun
);

  localparam int         IDX_W    = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [7:0] STABLE   = 8'(STABLE_CYC);
  localparam logic [7:0] STABLE_M = 8'(STABLE_CYC - 1);

  logic             legal;
  logic [IDX_W-1:0] idx;
  logic [IDX_W-1:0] prev_idx;
  logic [7:0]       prev_seg;
  logic [7:0]       cnt;
  logic             same;
  logic             capture;
  logic [3:0]       dec_nib;
  logic             dec_err;

  logic [4*NDIG-1:0] wk_hex, wk_hex_d;
  logic [NDIG-1:0]   wk_dp, wk_dp_d;
  logic [NDIG-1:0]   wk_err, wk_err_d;
  logic [NDIG-1:0]   mask, mask_set;
  logic              frame_done;

  state_t state, state_d;
  logic   load;
  logic   drop;

  always_comb begin
    legal = $onehot(~dig_en_n);
    idx   = '0;
    for (int i = 0; i < NDIG; i++) begin
      if (!dig_en_n[i]) idx = IDX_W'(i);
    end
  end

  // Capture fires only on the transition into STABLE, so a long dwell yields one capture.
  assign same    = (idx == prev_idx) && (seg_n == prev_seg);
  assign capture = legal && same && (cnt == STABLE_M);

  seg_to_hex u_dec (
    .pat (~seg_n[6:0]),
    .nib (dec_nib),
    .err (dec_err)
  );

  always_comb begin
    wk_hex_d = wk_hex;
    wk_dp_d  = wk_dp;
    wk_err_d = wk_err;
    mask_set = mask;
    if (capture) begin
      wk_hex_d[4*idx +: 4] = dec_nib;
      wk_dp_d[idx]         = ~seg_n[7];
      wk_err_d[idx]        = dec_err;
      mask_set[idx]        = 1'b1;
    end
  end

  assign frame_done = capture && (&mask_set);

  always_comb begin
    state_d = state;
    load    = 1'b0;
    drop    = 1'b0;
    case (state)
      COLLECT: begin
        if (frame_done) begin
          load    = 1'b1;
          state_d = PRESENT;
        end
      end
      PRESENT: begin
        if (frame_done) begin
          load = out_ready;
          drop = !out_ready;
        end else if (out_ready) begin
          state_d = COLLECT;
        end
      end
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= COLLECT;
      cnt      <= 8'd0;
      prev_idx <= '0;
      prev_seg <= 8'd0;
      mask     <= '0;
      wk_hex   <= '0;
      wk_dp    <= '0;
      wk_err   <= '0;
      out_hex  <= '0;
      out_dp   <= '0;
      out_err  <= '0;
      overrun  <= 1'b0;
    end else begin
      state   <= state_d;
      overrun <= drop;
      mask    <= frame_done ? '0 : mask_set;
      wk_hex  <= wk_hex_d;
      wk_dp   <= wk_dp_d;
      wk_err  <= wk_err_d;
      if (!legal) begin
        cnt <= 8'd0;
      end else begin
        prev_idx <= idx;
        prev_seg <= seg_n;
        if (!same)              cnt <= 8'd1;
        else if (cnt != STABLE) cnt <= cnt + 8'd1;
      end
      if (load) begin
        out_hex <= wk_hex_d;
        out_dp  <= wk_dp_d;
        out_err <= wk_err_d;
      end
    end
  end

  assign out_valid = (state == PRESENT);

endmodule

// File: tb/tb_seg_capture.sv
// Randomised and directed bench for seg_capture, compared cycle by cycle with
// a run-length based reference model of the display snooper.
module tb_seg_capture;

  localparam int NDIG = 4;
  localparam int SC   = 8;

  logic             clk = 1'b0;
  logic             reset;
  logic [7:0]       seg_n;
  logic [NDIG-1:0]  dig_en_n;
  logic [4*NDIG-1:0] out_hex;
  logic [NDIG-1:0]  out_dp;
  logic [NDIG-1:0]  out_err;
  logic             out_valid;
  logic             out_ready;
  logic             overrun;

  seg_capture #(.NDIG(NDIG), .STABLE_CYC(SC)) dut (
    .clk       (clk),
    .reset     (reset),
    .seg_n     (seg_n),
    .dig_en_n  (dig_en_n),
    .out_hex   (out_hex),
    .out_dp    (out_dp),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int vcount;
  int ovcount;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 'h%0h, expected 'h%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Digit glyphs as drawn on a display, active-high g..a.
  logic [6:0] glyph [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                             7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};

  function automatic logic [7:0] enc(input int v, input bit dp);
    return ~{dp, glyph[v]};
  endfunction

  // Reference model: length of the current run of identical legal samples,
  // digits seen this frame, and what the consumer should be seeing.
  int          run;
  int          last_idx;
  logic [7:0]  last_seg;
  logic [3:0]  wk_hex [NDIG];
  bit          wk_dp  [NDIG];
  bit          wk_err [NDIG];
  bit          got    [NDIG];
  logic [15:0] e_hex;
  logic [3:0]  e_dp, e_err;
  bit          e_valid, e_ovr;

  task automatic model_edge();
    int   lows, idx, nseen;
    bit   cap, done, ovr_n;
    logic [6:0] pat;
    lows = 0; idx = 0; cap = 0; done = 0; ovr_n = 0;
    if (reset) begin
      run = 0; last_idx = 0; last_seg = 8'h00;
      for (int i = 0; i < NDIG; i++) begin
        wk_hex[i] = 0; wk_dp[i] = 0; wk_err[i] = 0; got[i] = 0;
      end
      e_hex = 0; e_dp = 0; e_err = 0; e_valid = 0; e_ovr = 0;
      return;
    end
    for (int i = 0; i < NDIG; i++) if (dig_en_n[i] == 1'b0) begin lows++; idx = i; end
    if (lows != 1) begin
      run = 0;
    end else if (run > 0 && idx == last_idx && seg_n == last_seg) begin
      if (run < SC) begin
        run++;
        cap = (run == SC);
      end
    end else begin
      run = 1; last_idx = idx; last_seg = seg_n;
    end
    if (cap) begin
      pat = ~seg_n[6:0];
      wk_hex[idx] = 0; wk_err[idx] = 1;
      for (int v = 0; v < 16; v++) if (glyph[v] == pat) begin wk_hex[idx] = v; wk_err[idx] = 0; end
      wk_dp[idx] = ~seg_n[7];
      got[idx] = 1;
      nseen = 0;
      for (int i = 0; i < NDIG; i++) nseen += got[i];
      if (nseen == NDIG) begin
        done = 1;
        for (int i = 0; i < NDIG; i++) got[i] = 0;
      end
    end
    if (done) begin
      if (!e_valid || out_ready) begin
        for (int i = 0; i < NDIG; i++) begin
          e_hex[4*i +: 4] = wk_hex[i]; e_dp[i] = wk_dp[i]; e_err[i] = wk_err[i];
        end
        e_valid = 1;
      end else begin
        ovr_n = 1;
      end
    end else if (e_valid && out_ready) begin
      e_valid = 0;
    end
    e_ovr = ovr_n;
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("out_valid", out_valid, e_valid);
    check("out_hex", out_hex, e_hex);
    check("out_dp", out_dp, e_dp);
    check("out_err", out_err, e_err);
    check("overrun", overrun, e_ovr);
    if (out_valid) vcount++;
    if (overrun) ovcount++;
  endtask

  task automatic drive(input int d, input logic [7:0] s, input int n, input logic rdy);
    dig_en_n = ~(4'b0001 << d);
    seg_n = s;
    out_ready = rdy;
    repeat (n) step();
  endtask

  task automatic do_reset();
    reset = 1'b1; dig_en_n = 4'hF; seg_n = 8'hFF; out_ready = 1'b0;
    repeat (2) step();
    reset = 1'b0;
    vcount = 0; ovcount = 0;
  endtask

  task automatic scan(input int a, input int b, input int c, input int d,
                      input int n, input logic rdy);
    drive(0, enc(a, 0), n, rdy);
    drive(1, enc(b, 0), n, rdy);
    drive(2, enc(c, 0), n, rdy);
    drive(3, enc(d, 0), n, rdy);
  endtask

  initial begin
    reset = 1'b1; dig_en_n = 4'hF; seg_n = 8'hFF; out_ready = 1'b0;
    vcount = 0; ovcount = 0;
    do_reset();
    check("rst_hex", out_hex, 0);
    check("rst_valid", out_valid, 0);

    // basic 0,1,2,3 frame with a ready consumer
    scan(0, 1, 2, 3, 10, 1'b1);
    check("basic_hex", out_hex, 16'h3210);
    check("basic_dp", out_dp, 0);
    check("basic_err", out_err, 0);
    check("basic_vpulse", vcount, 1);

    // short dwell on digit 2 must not complete the frame
    do_reset();
    drive(0, enc(0, 0), 10, 1'b1);
    drive(1, enc(1, 0), 10, 1'b1);
    drive(2, enc(2, 0), 7, 1'b1);
    drive(3, enc(3, 0), 10, 1'b1);
    check("short_novalid", vcount, 0);
    drive(2, enc(2, 0), 8, 1'b1);
    check("short_done_valid", out_valid, 1);
    check("short_done_hex", out_hex, 16'h3210);

    // all segments + dp, then blank pattern
    do_reset();
    drive(0, 8'hC0, 10, 1'b0);
    drive(1, 8'h00, 10, 1'b0);
    drive(2, 8'hA4, 10, 1'b0);
    drive(3, 8'hB0, 10, 1'b0);
    check("eight_nib", out_hex[7:4], 8);
    check("eight_dp", out_dp[1], 1);
    do_reset();
    drive(0, 8'hC0, 10, 1'b0);
    drive(1, 8'hFF, 10, 1'b0);
    drive(2, 8'hA4, 10, 1'b0);
    drive(3, 8'hB0, 10, 1'b0);
    check("blank_nib", out_hex[7:4], 0);
    check("blank_err", out_err[1], 1);
    check("blank_dp", out_dp[1], 0);

    // backpressure: hold first, drop second, third arrives with ready
    do_reset();
    scan(1, 2, 3, 4, 10, 1'b0);
    check("bp_first", out_hex, 16'h4321);
    scan(5, 6, 7, 8, 10, 1'b0);
    check("bp_held", out_hex, 16'h4321);
    check("bp_ovr_once", ovcount, 1);
    drive(0, enc(9, 0), 10, 1'b0);
    drive(1, enc(10, 0), 10, 1'b0);
    drive(2, enc(11, 0), 10, 1'b0);
    drive(3, enc(12, 0), 7, 1'b0);
    drive(3, enc(12, 0), 1, 1'b1);
    check("bp_third_hex", out_hex, 16'hCBA9);
    check("bp_third_valid", out_valid, 1);
    drive(3, enc(12, 0), 2, 1'b1);
    check("bp_no_new_ovr", ovcount, 1);

    // two simultaneous enables are ignored and leave the mask alone
    do_reset();
    drive(0, enc(5, 1), 10, 1'b1);
    drive(1, enc(6, 0), 10, 1'b1);
    dig_en_n = 4'b1100; seg_n = enc(7, 0);
    repeat (20) step();
    check("multi_novalid", vcount, 0);
    drive(2, enc(7, 0), 10, 1'b1);
    drive(3, enc(8, 0), 10, 1'b1);
    check("multi_hex", out_hex, 16'h8765);
    check("multi_dp", out_dp, 4'b0001);

    // reset mid-frame discards captured digits
    drive(0, enc(1, 0), 10, 1'b1);
    drive(1, enc(1, 0), 10, 1'b1);
    drive(2, enc(1, 0), 10, 1'b1);
    do_reset();
    check("midrst_hex", out_hex, 0);
    drive(3, enc(2, 0), 10, 1'b1);
    check("midrst_novalid", vcount, 0);
    scan(4, 4, 4, 4, 9, 1'b1);
    check("midrst_valid", vcount, 1);

    // randomised scans with noise, glitches and random backpressure
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 19) == 0) do_reset();
      for (int d = 0; d < NDIG; d++) begin
        int   r;
        logic [7:0] s;
        r = $urandom_range(0, 9);
        s = (r < 8) ? enc($urandom_range(0, 15), 1'($urandom_range(0, 1))) : 8'($urandom);
        if ($urandom_range(0, 7) == 0) begin
          dig_en_n = 4'($urandom);
          seg_n = s;
          out_ready = 1'($urandom_range(0, 1));
          repeat ($urandom_range(1, 4)) step();
        end
        drive(($urandom_range(0, 9) == 0) ? $urandom_range(0, 3) : d, s,
              $urandom_range(5, 12), 1'($urandom_range(0, 1)));
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
